// File: rtl/lsu_pkg.sv
// Shared types and RV32I width codes for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_H, F3_HU: return lane[0];
            F3_W:        return lane != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        load_data = load_word;
        sel_byte  = load_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, word-wide memory port, RMW for SB/SH.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              req_error;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign req_error = !f3_legal(req_store, req_funct3) ||
                       misaligned(req_funct3, req_addr[1:0]) ||
                       (req_addr[31:2] >= 30'(DEPTH_WORDS));

    lsu_align u_align (
        .load_word  (mem_rdata),
        .lane       (addr_q[1:0]),
        .funct3     (funct3_q),
        .load_data  (load_data),
        .old_word   (rdata_q),
        .wdata      (wdata_q),
        .store_word (store_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q      <= req_store;
                        funct3_q     <= req_funct3;
                        addr_q       <= req_addr[ADDR_W+1:0];
                        wdata_q      <= req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= req_error;
                        if (req_error)                          state <= RESP;
                        else if (req_store && req_funct3 == F3_W) state <= WRITE;
                        else                                    state <= READ;
                    end
                end
                READ: begin
                    rdata_q <= mem_rdata;
                    if (store_q) begin
                        state <= WRITE;
                    end else begin
                        resp_rdata_q <= load_data;
                        state        <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port is decoded from state so reset drops it immediately.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = (state == READ);
    assign mem_write  = (state == WRITE);
    assign mem_addr   = (mem_read || mem_write) ? addr_q[ADDR_W+1:2] : '0;
    assign mem_wdata  = mem_write ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed vectors, multi-cycle corner sequences, randomized traffic vs a reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem     [512];
    logic [31:0] ref_mem [512];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    load_store_unit dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ctrl"}, {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'h10);
        check({tag, ".rdata"}, resp_rdata, 32'h0);
        check({tag, ".maddr"}, {23'd0, mem_addr}, 32'h0);
        check({tag, ".mwdata"}, mem_wdata, 32'h0);
    endtask

    // Reference model: byte-addressed semantics computed with plain arithmetic.
    function automatic void ref_access(input logic st, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er,
                                       output int lat, output int nr, output int nw);
        bit          legal;
        int          size, idx, sh;
        logic [31:0] w, mask;
        longint      v;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        er    = !legal || (a % size != 0) || (a >= 32'd2048);
        rd = 32'h0; nr = 0; nw = 0; lat = 1;
        if (!er) begin
            idx  = int'(a / 4);
            sh   = int'(a % 4) * 8;
            w    = ref_mem[idx];
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (size * 8)) - 32'h1);
            if (!st) begin
                v = longint'((w >> sh) & mask);
                if (!f3[2] && size < 4 && v >= (longint'(1) << (size * 8 - 1)))
                    v = v - (longint'(1) << (size * 8));
                rd  = v[31:0];
                lat = 2;
                nr  = 1;
            end else begin
                ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
                nw  = 1;
                nr  = (size < 4) ? 1 : 0;
                lat = (size < 4) ? 3 : 2;
            end
        end
    endfunction

    logic [31:0] r_rdata, r_wr_data;
    logic        r_err, r_bus_ok;
    logic [8:0]  r_rd_addr;
    int          r_lat, r_nr, r_nw;

    task automatic sample_bus();
        if (mem_read) begin
            r_nr++;
            r_rd_addr = mem_addr;
        end
        if (mem_write) begin
            r_nw++;
            r_wr_data = mem_wdata;
            mem[mem_addr] = mem_wdata;
        end
        if (mem_read && mem_write) r_bus_ok = 1'b0;
        if (!mem_read && !mem_write && (mem_addr != 9'd0 || mem_wdata != 32'd0)) r_bus_ok = 1'b0;
        if (req_ready) r_bus_ok = 1'b0;
    endtask

    // One transaction; hold > 0 keeps resp_ready low for that many response cycles.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
        bit seen = 1'b0;
        r_rdata = '0; r_err = 1'b0; r_lat = 0; r_nr = 0; r_nw = 0;
        r_rd_addr = '0; r_wr_data = '0; r_bus_ok = 1'b1;
        @(negedge clock);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = (hold == 0);
        if (!req_ready) r_bus_ok = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
            @(negedge clock);
            sample_bus();
            if (resp_valid) begin
                seen    = 1'b1;
                r_lat   = cyc;
                r_rdata = resp_rdata;
                r_err   = resp_err;
            end
        end
        if (!seen) check({tag, ".resp_timeout"}, 32'd0, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h0;
            sample_bus();
            if (!resp_valid || resp_rdata !== r_rdata || resp_err !== r_err) r_bus_ok = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        if (!req_ready || resp_valid) r_bus_ok = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          pre_idx;
        logic [31:0] pre_val;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nr;
        int          exp_nw;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, e_nr, e_nw, wr_seen;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;

        vecs[0]  = '{1'b0, F3_W,  32'h10,  32'h0,        4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 1, 0};
        vecs[1]  = '{1'b0, F3_B,  32'h13,  32'h0,        4, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 2, 1, 0};
        vecs[2]  = '{1'b0, F3_BU, 32'h13,  32'h0,       -1, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0};
        vecs[3]  = '{1'b0, F3_HU, 32'h12,  32'h0,       -1, 32'h0,         32'h0000_80FF, 1'b0, 2, 1, 0};
        vecs[4]  = '{1'b0, F3_H,  32'h12,  32'h0,       -1, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 1, 0};
        vecs[5]  = '{1'b1, F3_B,  32'h15,  32'hAB,       5, 32'h1122_3344, 32'h0,         1'b0, 3, 1, 1};
        vecs[6]  = '{1'b0, F3_W,  32'h14,  32'h0,       -1, 32'h0,         32'h1122_AB44, 1'b0, 2, 1, 0};
        vecs[7]  = '{1'b0, F3_W,  32'h2,   32'h0,       -1, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[8]  = '{1'b1, F3_H,  32'h801, 32'h5555,    -1, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[9]  = '{1'b0, F3_W,  32'h800, 32'h0,       -1, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[10] = '{1'b1, F3_H,  32'h16,  32'hCAFE,    -1, 32'h0,         32'h0,         1'b0, 3, 1, 1};
        vecs[11] = '{1'b0, F3_W,  32'h14,  32'h0,       -1, 32'h0,         32'hCAFE_AB44, 1'b0, 2, 1, 0};
        vecs[12] = '{1'b0, 3'b011, 32'h10, 32'h0,       -1, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[13] = '{1'b1, F3_BU, 32'h10,  32'h77,      -1, 32'h0,         32'h0,         1'b1, 1, 0, 0};
        vecs[14] = '{1'b0, F3_B,  32'h14,  32'h0,       -1, 32'h0,         32'h0000_0044, 1'b0, 2, 1, 0};
        vecs[15] = '{1'b1, F3_W,  32'h18,  32'h0BAD_F00D, 6, 32'h0,        32'h0,         1'b0, 2, 0, 1};
        vecs[16] = '{1'b0, F3_HU, 32'h1A,  32'h0,       -1, 32'h0,         32'h0000_0BAD, 1'b0, 2, 1, 0};
        vecs[17] = '{1'b0, F3_B,  32'h19,  32'h0,       -1, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 1, 0};
        vecs[18] = '{1'b1, F3_H,  32'h18,  32'h1234_5678, -1, 32'h0,       32'h0,         1'b0, 3, 1, 1};
        vecs[19] = '{1'b0, F3_W,  32'h18,  32'h0,       -1, 32'h0,         32'h0BAD_5678, 1'b0, 2, 1, 0};

        repeat (2) @(posedge clock);
        #1 check_reset_outputs("reset_hold");
        @(negedge clock) reset = 1'b0;
        #1 check_reset_outputs("after_reset");

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].pre_idx >= 0) mem[vecs[i].pre_idx] = vecs[i].pre_val;
            do_req($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0);
            check($sformatf("vec%0d.rdata", i), r_rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d.err", i), {31'd0, r_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d.latency", i), r_lat, vecs[i].exp_lat);
            check($sformatf("vec%0d.reads", i), r_nr, vecs[i].exp_nr);
            check($sformatf("vec%0d.writes", i), r_nw, vecs[i].exp_nw);
            check($sformatf("vec%0d.bus", i), {31'd0, r_bus_ok}, 32'd1);
            if (vecs[i].exp_nr > 0)
                check($sformatf("vec%0d.rd_addr", i), {23'd0, r_rd_addr}, (vecs[i].addr >> 2) & 32'h1FF);
            if (i == 5) check("sb_merge_wdata", r_wr_data, 32'h1122_AB44);
        end

        // Response back-pressure after SW.
        do_req("hold_sw", 1'b1, F3_W, 32'h20, 32'h5A5A_5A5A, 3);
        check("hold_sw.latency", r_lat, 2);
        check("hold_sw.err", {31'd0, r_err}, 32'd0);
        check("hold_sw.rdata", r_rdata, 32'd0);
        check("hold_sw.stable", {31'd0, r_bus_ok}, 32'd1);
        check("hold_sw.writes", r_nw, 1);
        check("hold_sw.mem", mem[8], 32'h5A5A_5A5A);
        check("hold_sw.ignored_req", mem[0], 32'h0);

        // Reset during the READ of an SB: no write may follow.
        mem[12] = 32'h1234_5678;
        @(negedge clock);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h30; req_wdata = 32'h77;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rst_mid.read_cycle", {31'd0, mem_read}, 32'd1);
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst_mid.async");
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        wr_seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (mem_write) wr_seen++;
        end
        check("rst_mid.no_write", wr_seen, 0);
        check("rst_mid.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid.mem", mem[12], 32'h1234_5678);
        do_req("rst_mid.reload", 1'b0, F3_W, 32'h30, 32'h0, 0);
        check("rst_mid.reload", r_rdata, 32'h1234_5678);

        // Randomized traffic over a small window so RMWs and loads overlap.
        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 300; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            int          sel;
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'h800 + 32'($urandom_range(0, 15) << 2);
            else               a = 32'($urandom_range(0, 63));
            wd = $urandom;
            ref_access(st, f3, a, wd, e_rd, e_err, e_lat, e_nr, e_nw);
            do_req($sformatf("rnd%0d", i), st, f3, a, wd, 0);
            check($sformatf("rnd%0d.rdata", i), r_rdata, e_rd);
            check($sformatf("rnd%0d.err", i), {31'd0, r_err}, {31'd0, e_err});
            check($sformatf("rnd%0d.latency", i), r_lat, e_lat);
            check($sformatf("rnd%0d.reads", i), r_nr, e_nr);
            check($sformatf("rnd%0d.writes", i), r_nw, e_nw);
            check($sformatf("rnd%0d.bus", i), {31'd0, r_bus_ok}, 32'd1);
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
